// File: rtl/dma_debug_trace_capture.sv
// Debug trace capture: records qualified probe words into a circular RAM,
// triggers on a masked match and freezes after a programmed post-trigger count.
module dma_debug_trace_capture #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [DATA_W-1:0]     trig_mask,
    input  logic [DATA_W-1:0]     trig_value,
    input  logic [DEPTH_LOG2-1:0] post_count,
    input  logic [DATA_W-1:0]     probe_data,
    input  logic                  probe_valid,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [1:0]            state,
    output logic [DEPTH_LOG2-1:0] trig_addr,
    output logic [DEPTH_LOG2-1:0] start_addr,
    output logic                  wrapped,
    output logic                  done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRETRIG  = 2'd1,
        S_POSTTRIG = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   trig_addr_q;
    logic [DEPTH_LOG2-1:0]   post_cnt_q;
    logic                    wrapped_q;
    logic [DATA_W-1:0]       rd_data_p1;
    logic                    vld_p1;
    logic [DATA_W-1:0]       mem [0:DEPTH-1];

    logic hit;
    logic capturing;
    logic wr_en;
    logic trig_now;
    logic post_step;

    function automatic logic trig_match(input logic [DATA_W-1:0] data,
                                        input logic [DATA_W-1:0] mask,
                                        input logic [DATA_W-1:0] value);
        return (data & mask) == (value & mask);
    endfunction

    // ARM wins over everything: the word presented alongside it is neither stored nor compared.
    always_comb begin
        hit       = probe_valid && trig_match(probe_data, trig_mask, trig_value);
        capturing = (state_q == S_PRETRIG) || (state_q == S_POSTTRIG);
        wr_en     = capturing && probe_valid && !arm && !rst;
        trig_now  = (state_q == S_PRETRIG) && hit && !arm;
        post_step = (state_q == S_POSTTRIG) && probe_valid && !arm;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_PRETRIG;
            end
            S_PRETRIG: begin
                if (arm)
                    state_d = S_PRETRIG;
                else if (hit)
                    state_d = (post_count == '0) ? S_DONE : S_POSTTRIG;
            end
            S_POSTTRIG: begin
                if (arm)
                    state_d = S_PRETRIG;
                else if (probe_valid && (post_cnt_q == DEPTH_LOG2'(1)))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (arm) state_d = S_PRETRIG;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
            wrapped_q   <= 1'b0;
            rd_data_p1  <= '0;
            vld_p1      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (arm) begin
                wr_ptr_q  <= '0;
                wrapped_q <= 1'b0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (&wr_ptr_q) wrapped_q <= 1'b1;
            end

            if (trig_now) begin
                trig_addr_q <= wr_ptr_q;
                post_cnt_q  <= post_count;
            end else if (post_step) begin
                post_cnt_q <= post_cnt_q - 1'b1;
            end

            // ---- read stage p1: registered RAM output, read-first against a same-cycle write
            vld_p1 <= rd_en;
            if (rd_en) rd_data_p1 <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= probe_data;
    end

    assign rd_data    = rd_data_p1;
    assign rd_valid   = vld_p1;
    assign state      = state_q;
    assign trig_addr  = trig_addr_q;
    assign start_addr = wrapped_q ? wr_ptr_q : '0;
    assign wrapped    = wrapped_q;
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_dma_debug_trace_capture.sv
// Directed bench for dma_debug_trace_capture: arm/trigger/post-count scenarios,
// wrap tracking, read-first behaviour, ARM priority and mid-capture reset.
module tb_dma_debug_trace_capture;

    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 9;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  arm;
    logic [DATA_W-1:0]     trig_mask;
    logic [DATA_W-1:0]     trig_value;
    logic [DEPTH_LOG2-1:0] post_count;
    logic [DATA_W-1:0]     probe_data;
    logic                  probe_valid;
    logic                  rd_en;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic [1:0]            state;
    logic [DEPTH_LOG2-1:0] trig_addr;
    logic [DEPTH_LOG2-1:0] start_addr;
    logic                  wrapped;
    logic                  done;

    int tests = 0;
    int fails = 0;

    dma_debug_trace_capture #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
        .probe_data(probe_data), .probe_valid(probe_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .state(state), .trig_addr(trig_addr), .start_addr(start_addr),
        .wrapped(wrapped), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] d);
        probe_data  = d;
        probe_valid = 1'b1;
        tick();
        probe_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [31:0] m, input logic [31:0] v, input int pc);
        trig_mask  = m;
        trig_value = v;
        post_count = DEPTH_LOG2'(pc);
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = DEPTH_LOG2'(a);
        tick();
        rd_en   = 1'b0;
        check({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig_mask = '0; trig_value = '0; post_count = '0;
        probe_data = '0; probe_valid = 1'b0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // reset values
        check("rst_state",   32'(state),      32'd0);
        check("rst_trig",    32'(trig_addr),  32'd0);
        check("rst_start",   32'(start_addr), 32'd0);
        check("rst_wrapped", 32'(wrapped),    32'd0);
        check("rst_done",    32'(done),       32'd0);
        check("rst_rdvld",   32'(rd_valid),   32'd0);
        check("rst_rddata",  rd_data,         32'd0);

        // wrapping capture, trigger on low half 0x1234, four post words
        do_arm(32'h0000FFFF, 32'h00001234, 4);
        check("t2_armed", 32'(state), 32'd1);
        for (int i = 0; i <= 32'h1238; i++) begin
            feed(32'(i));
            if (i == 510)     check("t2_nowrap", 32'(wrapped), 32'd0);
            if (i == 511)     check("t2_wrap",   32'(wrapped), 32'd1);
            if (i == 32'h1233) check("t2_pre",   32'(state),   32'd1);
            if (i == 32'h1234) begin
                check("t2_post", 32'(state),     32'd2);
                check("t2_trig", 32'(trig_addr), 32'h034);
            end
            if (i == 32'h1237) check("t2_post3", 32'(state), 32'd2);
        end
        check("t2_state", 32'(state),      32'd3);
        check("t2_done",  32'(done),       32'd1);
        check("t2_trig2", 32'(trig_addr),  32'h034);
        check("t2_start", 32'(start_addr), 32'h039);
        feed(32'hFFFF_FFFF);
        read_chk("t2_rd_trig",   32'h034, 32'h00001234);
        read_chk("t2_rd_last",   32'h038, 32'h00001238);
        read_chk("t2_rd_oldest", 32'h039, 32'h00001039);
        tick();
        check("t2_rdvld_low", 32'(rd_valid), 32'd0);

        // no ARM after reset: nothing stored
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 100; i++) feed(32'hDEAD_0000 + 32'(i));
        check("t1_state", 32'(state), 32'd0);
        read_chk("t1_rd0",  0,       32'h00001200);
        read_chk("t1_rd34", 32'h034, 32'h00001234);

        // mask zero, post count zero
        do_arm(32'h0, 32'h0, 0);
        feed(32'hCAFE_F00D);
        check("t3_state", 32'(state),     32'd3);
        check("t3_done",  32'(done),      32'd1);
        check("t3_trig",  32'(trig_addr), 32'd0);
        read_chk("t3_rd0", 0, 32'hCAFE_F00D);

        // trigger after 10 words, gaps between post words
        do_arm(32'hFFFF_FFFF, 32'hABCD_0010, 3);
        for (int i = 0; i < 10; i++) feed(32'h100 + 32'(i));
        feed(32'hABCD_0010);
        check("t4_post", 32'(state),     32'd2);
        check("t4_trig", 32'(trig_addr), 32'd10);
        for (int j = 0; j < 3; j++) begin
            repeat (5) tick();
            if (j == 2) check("t4_gap", 32'(state), 32'd2);
            feed(32'h200 + 32'(j));
        end
        check("t4_done",    32'(done),       32'd1);
        feed(32'h300);
        check("t4_wrapped", 32'(wrapped),    32'd0);
        check("t4_start",   32'(start_addr), 32'd0);
        read_chk("t4_rd11", 11, 32'h200);
        read_chk("t4_rd12", 12, 32'h201);
        read_chk("t4_rd13", 13, 32'h202);
        read_chk("t4_rd14", 14, 32'h0000120E);

        // ARM coincident with a hit while in POSTTRIG
        do_arm(32'hFFFF_FFFF, 32'h55, 5);
        feed(32'h11);
        feed(32'h55);
        check("t5_post", 32'(state),     32'd2);
        check("t5_trig", 32'(trig_addr), 32'd1);
        feed(32'h22);
        arm = 1'b1; probe_data = 32'h55; probe_valid = 1'b1;
        tick();
        arm = 1'b0; probe_valid = 1'b0;
        check("t5_rearm", 32'(state), 32'd1);
        rd_en = 1'b1; rd_addr = '0; probe_data = 32'h77; probe_valid = 1'b1;
        tick();
        rd_en = 1'b0; probe_valid = 1'b0;
        check("t5_rdfirst", rd_data, 32'h11);
        check("t5_pre",     32'(state), 32'd1);
        read_chk("t5_rd0", 0, 32'h77);
        read_chk("t5_rd3", 3, 32'h103);

        // reset in POSTTRIG
        feed(32'h55);
        check("t6_post", 32'(state),     32'd2);
        check("t6_trig", 32'(trig_addr), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_state",   32'(state),      32'd0);
        check("t6_done",    32'(done),       32'd0);
        check("t6_trig0",   32'(trig_addr),  32'd0);
        check("t6_wrapped", 32'(wrapped),    32'd0);
        check("t6_start",   32'(start_addr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
